checkout_accumulator: RTL

Parametrised successor to the scale/price calculator: forms the registered line subtotal `weight*price`, adds it to a running sum on a debounced-edge "add" press, and keeps an item count. New over the previous generation: configurable widths, an undo stack of the last `HIST_DEPTH` additions, a synchronous clear, saturating arithmetic with a sticky overflow flag, and an explicit lock FSM that rejects repeat adds until the entry changes. It sits between the switch/button front end and the display driver.

---
 rtl/checkout_accumulator.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/checkout_accumulator.sv
// checkout_accumulator: registered weight*price line subtotal, running sum with
// saturating adds, an undo stack of the most recent deltas, synchronous clear,
// and a lock FSM that refuses repeat adds until the weight/price entry changes.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// ARMED  | next add pulse is accepted
// LOCKED | an add was taken for the captured entry; adds ignored until the
//        | registered weight or price differs from the captured pair, or clear
module checkout_accumulator #(
   parameter int W_WIDTH    = 4,
   parameter int P_WIDTH    = 4,
   parameter int SUM_WIDTH  = 16,
   parameter int CNT_WIDTH  = 4,
   parameter int HIST_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [W_WIDTH-1:0]           weight,
   input  logic [P_WIDTH-1:0]           price,
   input  logic                         add_btn,
   input  logic                         undo_btn,
   input  logic                         clear_btn,
   output logic [W_WIDTH+P_WIDTH-1:0]   single,
   output logic [SUM_WIDTH-1:0]         sum,
   output logic [CNT_WIDTH-1:0]         item_count,
   output logic                         overflow,
   output logic                         locked,
   output logic                         hist_empty,
   output logic                         hist_full
);

   localparam int S_WIDTH = W_WIDTH + P_WIDTH;
   localparam int PTR_W   = $clog2(HIST_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam logic [SUM_WIDTH-1:0] SUM_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic {ARMED = 1'b0, LOCKED = 1'b1} state_t;

   // button synchronisers: bit 0 add, bit 1 undo, bit 2 clear
   logic [2:0] btn_raw;
   logic [2:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, ok_q, ok_d;
   logic       started_q, started_d;
   logic [2:0] pulse;

   state_t                 state_q, state_d;
   logic [S_WIDTH-1:0]     single_q, single_d;
   logic [W_WIDTH-1:0]     w_q, w_d, cap_w_q, cap_w_d;
   logic [P_WIDTH-1:0]     p_q, p_d, cap_p_q, cap_p_d;
   logic [SUM_WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic [S_WIDTH-1:0]     hist_q [HIST_DEPTH];
   logic [S_WIDTH-1:0]     hist_d [HIST_DEPTH];
   logic [PTR_W-1:0]       top_q, top_d, top_dec;
   logic [LVL_W-1:0]       lvl_q, lvl_d;
   logic                   empty_q, empty_d, full_q, full_d;

   logic [SUM_WIDTH-1:0]   single_ext, headroom, delta_ext;
   logic                   entry_changed;

   assign btn_raw = {clear_btn, undo_btn, add_btn};

   // Edge detect; ok_q masks a button until it has been seen low after reset,
   // so a level held across reset release never produces a pulse.
   always_comb begin
      s1_d      = btn_raw;
      s2_d      = s1_q;
      prev_d    = s2_q;
      started_d = 1'b1;
      ok_d      = ok_q | ({3{started_q}} & ~s1_q);
      pulse     = s2_q & ~prev_q & ok_q;
   end

   // Saturating add amount and entry-change detection on the registered entry
   always_comb begin
      single_ext    = SUM_WIDTH'(single_q);
      headroom      = SUM_MAX - sum_q;
      delta_ext     = (single_ext > headroom) ? headroom : single_ext;
      entry_changed = (w_q != cap_w_q) || (p_q != cap_p_q);
      top_dec       = top_q - 1'b1;
   end

   // Next state: clear > undo > add, plus lock release on entry change
   always_comb begin
      single_d = S_WIDTH'(weight) * S_WIDTH'(price);
      w_d      = weight;
      p_d      = price;
      state_d  = state_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      hist_d   = hist_q;
      top_d    = top_q;
      lvl_d    = lvl_q;
      cap_w_d  = cap_w_q;
      cap_p_d  = cap_p_q;

      if (state_q == LOCKED && entry_changed) state_d = ARMED;

      if (pulse[2]) begin
         sum_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         top_d   = '0;
         lvl_d   = '0;
         state_d = ARMED;
      end else if (pulse[1]) begin
         if (lvl_q != '0) begin
            sum_d = sum_q - SUM_WIDTH'(hist_q[top_dec]);
            top_d = top_dec;
            lvl_d = lvl_q - 1'b1;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         end
      end else if (pulse[0] && state_q == ARMED) begin
         sum_d         = sum_q + delta_ext;
         if (single_ext > headroom) ovf_d = 1'b1;
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         hist_d[top_q] = S_WIDTH'(delta_ext);
         top_d         = top_q + 1'b1;
         if (lvl_q != LVL_W'(HIST_DEPTH)) lvl_d = lvl_q + 1'b1;
         cap_w_d       = w_q;
         cap_p_d       = p_q;
         state_d       = LOCKED;
      end

      empty_d = (lvl_d == '0);
      full_d  = (lvl_d == LVL_W'(HIST_DEPTH));
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q      <= '0;
         s2_q      <= '0;
         prev_q    <= '0;
         ok_q      <= '0;
         started_q <= 1'b0;
         state_q   <= ARMED;
         single_q  <= '0;
         w_q       <= '0;
         p_q       <= '0;
         cap_w_q   <= '0;
         cap_p_q   <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         hist_q    <= '{default: '0};
         top_q     <= '0;
         lvl_q     <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         prev_q    <= prev_d;
         ok_q      <= ok_d;
         started_q <= started_d;
         state_q   <= state_d;
         single_q  <= single_d;
         w_q       <= w_d;
         p_q       <= p_d;
         cap_w_q   <= cap_w_d;
         cap_p_q   <= cap_p_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         hist_q    <= hist_d;
         top_q     <= top_d;
         lvl_q     <= lvl_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
      end
   end

   assign single     = single_q;
   assign sum        = sum_q;
   assign item_count = cnt_q;
   assign overflow   = ovf_q;
   assign locked     = (state_q == LOCKED);
   assign hist_empty = empty_q;
   assign hist_full  = full_q;

endmodule
